delay_line: RTL and testbench
=============================

DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data bus width in bits; legal range 1 and up.
REQ-002 SHALL have parameter DELAY, default 1, latency in clock cycles from din to dout; legal range 0 and up.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high; instantiations that do not need reset tie it to 0.
REQ-005 SHALL have port din  input  WIDTH  data sampled every clk rising edge.
REQ-006 SHALL have port dout  output  WIDTH  din delayed by DELAY cycles.
REQ-007 SHALL have, only when DELAY_LINE_VALID_EN is defined, ports din_valid (input, 1 bit) and dout_valid (output, 1 bit), a qualifier travelling alongside data.

Function
REQ-008 SHALL implement a chain of DELAY registers, each WIDTH bits wide; stage 0 loads din, and stage k loads stage k-1.
REQ-009 SHALL drive dout from the last stage, so dout at cycle n+DELAY equals din sampled at cycle n.
REQ-010 SHALL, when DELAY = 0, connect dout combinationally to din with no registers, no clk dependence and rst ignored.
REQ-011 SHALL advance every stage every clock; there is no stall or enable input.
REQ-012 SHALL power up and initialise every stage to all-zeros, so dout reads 0 before any data has propagated.
REQ-013 SHALL pass data bit-exact with no arithmetic, sign or width change.
REQ-014 SHALL fail elaboration with a clear message if DELAY < 0 or WIDTH < 1.

Reset
REQ-015 SHALL clear all stages to zero on any rising clk edge where rst = 1; dout = 0 from the next cycle.
REQ-016 SHALL, on reset mid-stream, discard in-flight data; din values presented while rst = 1 are not captured.
REQ-017 SHALL resume capturing din on the first edge with rst = 0; that value appears on dout DELAY cycles later, with zeros shown before it.

Configuration
REQ-018 SHALL, with macro DELAY_LINE_VALID_EN defined, delay din_valid through a parallel 1-bit chain of the same DELAY, so dout_valid aligns exactly with dout.
REQ-019 SHALL, with DELAY_LINE_VALID_EN defined, clear the valid chain on rst and set the power-up value of every valid stage to 0.
REQ-020 SHALL, with DELAY_LINE_VALID_EN defined and DELAY = 0, pass din_valid combinationally to dout_valid.
REQ-021 SHALL, without DELAY_LINE_VALID_EN, omit the valid ports and logic entirely; the data path is unchanged.

Structure
REQ-022 SHALL take parameter defaults (WIDTH 1, DELAY 1) from constants DELAY_LINE_DEFAULT_WIDTH and DELAY_LINE_DEFAULT_DELAY in shared package delay_line_pkg; there are no typedefs.
REQ-023 SHALL build the chain from generated instances of one sub-module, delay_line_stage: a WIDTH-bit register with synchronous active-high clear and zero initial value.
REQ-024 SHALL be usable as the output pipeline of an inferred RAM, with DELAY = latency-1 and din fed from the RAM's registered read data.

Verification
REQ-025 SHALL cover WIDTH=8, DELAY=3, rst=0, din = 0x01,0x02,0x03,... on consecutive cycles -> dout = 0,0,0, then 0x01,0x02,0x03,... exactly 3 cycles behind din.
REQ-026 SHALL cover WIDTH=8, DELAY=0, din stepping 0xA5 then 0x5A within a cycle -> dout follows combinationally, including while rst=1.
REQ-027 SHALL cover WIDTH=8, DELAY=4, streaming 0x10..0x1F with rst=1 for 2 cycles mid-stream -> dout = 0x00 from the edge after reset for 4 cycles, then the first post-reset din value.
REQ-028 SHALL cover WIDTH=72, DELAY=1, din = all-ones then 0 -> dout = all-ones one cycle later, then 0; the all-zero value is checked before the first edge.
REQ-029 SHALL cover DELAY_LINE_VALID_EN defined, DELAY=2, din_valid pulsed for one cycle with din=0x3C -> dout_valid pulses exactly 2 cycles later, coincident with dout=0x3C.
REQ-030 SHALL cover randomized din over 1000 cycles for DELAY in {1,2,7} -> every output matches a reference queue of depth DELAY.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared constants for the delay_line block and its stage register.
// Optional feature macro used by this block: DELAY_LINE_VALID_EN.
package delay_line_pkg;

    // Default data bus width in bits.
    localparam int DELAY_LINE_DEFAULT_WIDTH = 1;

    // Default latency in clock cycles from din to dout.
    localparam int DELAY_LINE_DEFAULT_DELAY = 1;

endpackage : delay_line_pkg

// File: rtl/delay_line_stage.sv
// One stage of the delay line: a WIDTH-bit register with a synchronous
// active-high clear and an all-zero power-up value.
// Optional feature macro of the enclosing block: DELAY_LINE_VALID_EN
// (this stage is reused unchanged for the valid chain).
module delay_line_stage
    import delay_line_pkg::*;
#(
    parameter int WIDTH = DELAY_LINE_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // The declaration initialiser gives the register its zero power-up
    // value, so dout reads zero before any data has propagated.
    logic [WIDTH-1:0] data_q = '0;
    logic [WIDTH-1:0] data_d;

    // Next state is simply the upstream value; the clear has priority in the register.
    always_comb begin
        data_d = d_i;
    end

    // Stage register: clear to zero on clr_i, otherwise load every cycle.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : delay_line_stage

// File: rtl/delay_line.sv
// Fixed-latency delay line: dout is din delayed by DELAY clock cycles.
// DELAY = 0 degenerates to a combinational wire (clk and rst unused).
// Defining DELAY_LINE_VALID_EN adds din_valid/dout_valid, a 1-bit
// qualifier delayed by a parallel chain so it stays aligned with dout.
// Typical use: output pipeline of an inferred RAM, with DELAY set to the
// remaining latency and din taken from the RAM's registered read data.
module delay_line
    import delay_line_pkg::*;
#(
    parameter int WIDTH = DELAY_LINE_DEFAULT_WIDTH,
    parameter int DELAY = DELAY_LINE_DEFAULT_DELAY
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DELAY_LINE_VALID_EN
    input  logic             din_valid,
    output logic             dout_valid,
`endif
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Reject illegal parameterisations at elaboration time.
    if (WIDTH < 1) begin : g_bad_width
        $error("delay_line: WIDTH must be at least 1 (got %0d)", WIDTH);
    end
    if (DELAY < 0) begin : g_bad_delay
        $error("delay_line: DELAY must be 0 or greater (got %0d)", DELAY);
    end

    if (DELAY <= 0) begin : g_bypass
        // Zero latency: straight wire, no registers, reset has no effect.
        assign dout = din;
`ifdef DELAY_LINE_VALID_EN
        assign dout_valid = din_valid;
`endif
    end else begin : g_chain
        // data_tap[0] is the input, data_tap[k] is the output of stage k-1.
        logic [WIDTH-1:0] data_tap [DELAY+1];

        assign data_tap[0] = din;

        for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
            delay_line_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk   (clk),
                .clr_i (rst),
                .d_i   (data_tap[gi]),
                .q_o   (data_tap[gi+1])
            );
        end

        assign dout = data_tap[DELAY];

`ifdef DELAY_LINE_VALID_EN
        // Qualifier chain, identical depth and reset so it lines up with dout.
        logic valid_tap [DELAY+1];

        assign valid_tap[0] = din_valid;

        for (genvar gi = 0; gi < DELAY; gi++) begin : g_valid_stage
            delay_line_stage #(
                .WIDTH (1)
            ) u_valid_stage (
                .clk   (clk),
                .clr_i (rst),
                .d_i   (valid_tap[gi]),
                .q_o   (valid_tap[gi+1])
            );
        end

        assign dout_valid = valid_tap[DELAY];
`endif
    end

endmodule : delay_line

// File: tb/tb_delay_line.sv
// Scoreboard bench for delay_line. Several 8-bit instances with different
// DELAY values run side by side, plus a 72-bit DELAY=1 instance. The
// reference model keeps, per instance, a queue of the last DELAY captured
// {valid,data} words; a reset edge refills it with zeros. The stimulus
// process pushes the expected output for each cycle into a per-instance
// queue and a negedge monitor pops and compares.
// Build with +define+DELAY_LINE_VALID_EN to also check the valid chain.
module tb_delay_line;

    localparam int NI   = 7;
    localparam int NCYC = 1100;

    // Instance delays: 0:D3 counting, 1:D0 comb, 2:D4 reset mid-stream,
    // 3..5: random D1/D2/D7, 6: D2 valid-pulse instance.
    function automatic int dly_of(input int i);
        case (i)
            0: return 3;
            1: return 0;
            2: return 4;
            3: return 1;
            4: return 2;
            5: return 7;
            default: return 2;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_w  [NI];
    logic [7:0]  din_w  [NI];
    logic [7:0]  dout_w [NI];
    logic        vin_w  [NI];
    logic        vout_w [NI];

    logic        rst72;
    logic [71:0] din72;
    logic [71:0] dout72;
    logic        vin72;
    logic        vout72;

    int n_checks = 0;
    int n_fail   = 0;
    bit running  = 1'b0;

    logic [8:0]  exp_q [NI][$];
    logic [8:0]  hist  [NI][$];
    logic [72:0] exp72_q[$];
    logic [72:0] hist72;
    logic [8:0]  mon_e;
    logic [72:0] mon_e72;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        delay_line #(
            .WIDTH (8),
            .DELAY (dly_of(gi))
        ) u_dut (
            .clk        (clk),
            .rst        (rst_w[gi]),
`ifdef DELAY_LINE_VALID_EN
            .din_valid  (vin_w[gi]),
            .dout_valid (vout_w[gi]),
`endif
            .din        (din_w[gi]),
            .dout       (dout_w[gi])
        );
    end

    delay_line #(
        .WIDTH (72),
        .DELAY (1)
    ) u_dut72 (
        .clk        (clk),
        .rst        (rst72),
`ifdef DELAY_LINE_VALID_EN
        .din_valid  (vin72),
        .dout_valid (vout72),
`endif
        .din        (din72),
        .dout       (dout72)
    );

    task automatic check(input string name, input int idx,
                         input logic [71:0] act, input logic [71:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, act, expv);
        end
    endtask

    // Inputs applied during cycle c (captured at the following rising edge).
    task automatic gen_inputs(input int c);
        for (int i = 0; i < NI; i++) begin
            case (i)
                0: begin
                    din_w[i] = 8'(c + 1);
                    rst_w[i] = 1'b0;
                    vin_w[i] = 1'b1;
                end
                1: begin
                    din_w[i] = 8'($urandom);
                    rst_w[i] = 1'($urandom_range(1, 0));
                    vin_w[i] = 1'($urandom_range(1, 0));
                end
                2: begin
                    din_w[i] = 8'h10 + 8'(c % 16);
                    rst_w[i] = (c == 8 || c == 9);
                    vin_w[i] = 1'b1;
                end
                6: begin
                    rst_w[i] = 1'b0;
                    if (c < 20) begin
                        din_w[i] = (c == 10) ? 8'h3C : 8'($urandom);
                        vin_w[i] = (c == 10);
                    end else begin
                        din_w[i] = 8'($urandom);
                        vin_w[i] = 1'($urandom_range(1, 0));
                    end
                end
                default: begin
                    din_w[i] = 8'($urandom);
                    rst_w[i] = ($urandom_range(96, 0) == 0);
                    vin_w[i] = 1'($urandom_range(1, 0));
                end
            endcase
        end
        rst72 = 1'b0;
        vin72 = (c == 0);
        if (c == 0)
            din72 = {72{1'b1}};
        else if (c < 5)
            din72 = '0;
        else
            din72 = {8'($urandom), $urandom, $urandom};
    endtask

    // Reference model: what each rising edge does to the last-DELAY history.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (dly_of(i) > 0) begin
                if (rst_w[i]) begin
                    for (int k = 0; k < dly_of(i); k++) hist[i][k] = '0;
                end else begin
                    hist[i].push_back({vin_w[i], din_w[i]});
                    void'(hist[i].pop_front());
                end
            end
        end
        hist72 = rst72 ? '0 : {vin72, din72};
    endtask

    task automatic push_expect();
        for (int i = 0; i < NI; i++) begin
            if (dly_of(i) == 0)
                exp_q[i].push_back({vin_w[i], din_w[i]});
            else
                exp_q[i].push_back(hist[i][0]);
        end
        exp72_q.push_back(hist72);
    endtask

    // Monitor: every cycle each instance presents one output word.
    always @(negedge clk) begin
        if (running) begin
            for (int i = 0; i < NI; i++) begin
                if (exp_q[i].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty[%0d] at %0t: got no expectation, required one", i, $time);
                end else begin
                    mon_e = exp_q[i].pop_front();
                    check("dout", i, {64'd0, dout_w[i]}, {64'd0, mon_e[7:0]});
`ifdef DELAY_LINE_VALID_EN
                    check("dout_valid", i, {71'd0, vout_w[i]}, {71'd0, mon_e[8]});
`endif
                end
            end
            if (exp72_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty72 at %0t: got no expectation, required one", $time);
            end else begin
                mon_e72 = exp72_q.pop_front();
                check("dout72", 0, dout72, mon_e72[71:0]);
`ifdef DELAY_LINE_VALID_EN
                check("dout_valid72", 0, {71'd0, vout72}, {71'd0, mon_e72[72]});
`endif
            end
        end
    end

    initial begin
        hist72 = '0;
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < dly_of(i); k++) hist[i].push_back(9'd0);

        gen_inputs(0);
        #1;
        // Power-up state before any edge.
        check("pre_edge_dout72", 0, dout72, 72'd0);
        check("pre_edge_dout_d3", 0, {64'd0, dout_w[0]}, 72'd0);

        // DELAY=0: follows din within a cycle, even with rst high.
        rst_w[1] = 1'b1;
        din_w[1] = 8'hA5;
        vin_w[1] = 1'b1;
        #1;
        check("comb_a5", 1, {64'd0, dout_w[1]}, {64'd0, 8'hA5});
`ifdef DELAY_LINE_VALID_EN
        check("comb_valid1", 1, {71'd0, vout_w[1]}, 72'd1);
`endif
        din_w[1] = 8'h5A;
        vin_w[1] = 1'b0;
        #1;
        check("comb_5a", 1, {64'd0, dout_w[1]}, {64'd0, 8'h5A});
`ifdef DELAY_LINE_VALID_EN
        check("comb_valid0", 1, {71'd0, vout_w[1]}, 72'd0);
`endif

        running = 1'b1;
        for (int c = 1; c <= NCYC; c++) begin
            @(posedge clk);
            #1;
            model_edge();
            gen_inputs(c);
            push_expect();
        end
        @(posedge clk);
        #1;
        running = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_delay_line
